// File: rtl/twinkle_engine.sv
// N-channel twinkle generator: each channel runs a rise/hold/fall intensity envelope,
// started at random by a 16-bit Galois LFSR or on demand by the host force mask.
module twinkle_engine #(
  parameter int          N      = 24,
  parameter int          W      = 3,
  parameter int          STEP   = 1,
  parameter int          SPARSE = 2,
  parameter logic [15:0] SEED   = 16'hFFFF,
  parameter int          HW     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  input  logic                   enable,
  input  logic [W-1:0]           peak,
  input  logic [HW-1:0]          hold_ticks,
  input  logic [$clog2(N+1)-1:0] max_active,
  input  logic [N-1:0]           force_mask,
  output logic [N*W-1:0]         intensities,
  output logic [N-1:0]           active,
  output logic [$clog2(N+1)-1:0] active_count,
  // per-channel FSM state, 2 bits each: 0 idle, 1 rise, 2 hold, 3 fall
  output logic [2*N-1:0]         state_dbg
);

  localparam int          CW        = $clog2(N + 1);
  localparam int          IW        = $clog2(N) + SPARSE;
  localparam logic [15:0] LFSR_INIT = (SEED == 16'h0000) ? 16'hFFFF : SEED;
  localparam logic [W:0]  STEP_X    = STEP[W:0];
  localparam logic [IW:0] N_X       = N[IW:0];

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RISE = 2'd1,
    S_HOLD = 2'd2,
    S_FALL = 2'd3
  } ch_state_t;

  ch_state_t     state_q  [N];
  ch_state_t     state_d  [N];
  logic [W-1:0]  level_q  [N];
  logic [W-1:0]  level_d  [N];
  logic [HW-1:0] cnt_q    [N];
  logic [HW-1:0] cnt_d    [N];
  logic [W:0]    rise_sum [N];

  logic [15:0]   lfsr_q;
  logic [15:0]   lfsr_next;
  logic [IW-1:0] cand;
  logic          cand_ok;
  logic          budget_ok;
  logic [N-1:0]  force_start;
  logic [N-1:0]  rand_start;
  logic [N-1:0]  start;
  logic [CW-1:0] n_forced;
  logic [CW-1:0] count_d;

  assign lfsr_next = {lfsr_q[14:0], 1'b0} ^ (lfsr_q[15] ? 16'h002D : 16'h0000);
  assign cand      = lfsr_q[IW-1:0];
  assign cand_ok   = {1'b0, cand} < N_X;

  // Forced starts are counted first so they consume the random-start budget.
  always_comb begin
    force_start = '0;
    rand_start  = '0;
    start       = '0;
    n_forced    = '0;
    budget_ok   = 1'b0;
    for (int i = 0; i < N; i++) begin
      force_start[i] = tick && (peak != '0) && force_mask[i] && (state_q[i] == S_IDLE);
      n_forced       = n_forced + CW'(force_start[i]);
    end
    budget_ok = ({1'b0, active_count} + {1'b0, n_forced}) < {1'b0, max_active};
    for (int i = 0; i < N; i++) begin
      rand_start[i] = tick && (peak != '0) && enable && cand_ok && (cand == IW'(i))
                      && (state_q[i] == S_IDLE) && !force_start[i] && budget_ok;
    end
    start = force_start | rand_start;
  end

  // Envelope next-state; all sums are one bit wider so nothing wraps.
  always_comb begin
    count_d = '0;
    for (int i = 0; i < N; i++) begin
      state_d[i]  = state_q[i];
      level_d[i]  = level_q[i];
      cnt_d[i]    = cnt_q[i];
      rise_sum[i] = {1'b0, level_q[i]} + STEP_X;
      if (tick) begin
        case (state_q[i])
          S_IDLE: begin
            level_d[i] = '0;
            if (start[i]) state_d[i] = S_RISE;
          end
          S_RISE: begin
            if (rise_sum[i] >= {1'b0, peak}) begin
              level_d[i] = peak;
              if (hold_ticks == '0) begin
                state_d[i] = S_FALL;
              end else begin
                state_d[i] = S_HOLD;
                cnt_d[i]   = hold_ticks;
              end
            end else begin
              level_d[i] = rise_sum[i][W-1:0];
            end
          end
          S_HOLD: begin
            if (cnt_q[i] <= HW'(1)) begin
              state_d[i] = S_FALL;
              level_d[i] = ({1'b0, level_q[i]} > STEP_X) ? level_q[i] - STEP_X[W-1:0] : '0;
            end else begin
              cnt_d[i] = cnt_q[i] - HW'(1);
            end
          end
          S_FALL: begin
            if ({1'b0, level_q[i]} <= STEP_X) begin
              level_d[i] = '0;
              state_d[i] = S_IDLE;
            end else begin
              level_d[i] = level_q[i] - STEP_X[W-1:0];
            end
          end
          default: state_d[i] = S_IDLE;
        endcase
      end
      count_d = count_d + CW'(state_d[i] != S_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= S_IDLE;
        level_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
      lfsr_q       <= LFSR_INIT;
      active_count <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        level_q[i] <= level_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      active_count <= count_d;
      if (tick) lfsr_q <= lfsr_next;
    end
  end

  always_comb begin
    intensities = '0;
    active      = '0;
    state_dbg   = '0;
    for (int i = 0; i < N; i++) begin
      intensities[i*W +: W] = level_q[i];
      active[i]             = (state_q[i] != S_IDLE);
      state_dbg[2*i +: 2]   = state_q[i];
    end
  end

endmodule
